pc_seq_ctrl: RTL and testbench
==============================

Name: pc_seq_ctrl

Overview:
- Next-PC controller that sequences the 32-bit PC register.
- Each cycle it picks the PC source: boot, sequential, branch, return, hazard hold or interrupt vector.
- It drives the PC register's write data, hold code, fetch-NOP, clear and vector-load strobes.
- It owns the interrupt entry sequence: drain the pipeline, save the return PC, load the vector.

Parameters:
- INT_VECTOR, 32'h20: interrupt vector address; the PC register loads it on pc_load_vec.
- DRAIN_CYCLES, 3: cycles the PC is frozen before vectoring (range 1..15).
- PC_W, 32: PC width.

Ports:
- clk  in  1  system clock; controller state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- pc_cur  in  PC_W  current PC register value.
- instr_is_32  in  1  fetched instruction carries an immediate word; step is 2 instead of 1.
- stall_req  in  1  load-use hazard from decode.
- branch_taken  in  1  taken branch/jump resolved in execute.
- branch_target  in  PC_W  branch destination.
- ret_valid  in  1  RET/RTI address available from memory stage.
- ret_addr  in  PC_W  popped return address.
- int_req  in  1  level interrupt request.
- pc_wr_data  out  PC_W  next PC value.
- pc_no_change  out  2  00 = write, 01 = hold (interrupt drain), 11 = hold (reset).
- pc_fetch_nop  out  1  suppress PC write and inject a NOP at fetch.
- pc_reset  out  1  clear the PC to 0.
- pc_load_vec  out  1  load INT_VECTOR into the PC.
- flush  out  1  flush IF/ID.
- int_ack  out  1  one-cycle interrupt acknowledge.
- int_save_valid  out  1  int_save_pc valid, for the stack push.
- int_save_pc  out  PC_W  return PC for the interrupt.

Behaviour:
- Registered state: FSM, 4-bit drain counter, save_pc register, int_armed flag. All update on posedge clk.
- Outputs are combinational from state and inputs, so they settle before the PC register's negedge write.
- Reset (rst_n = 0 at a posedge):
  - Next state is BOOT; counter = 0; save_pc = 0; int_armed = 1.
  - While rst_n = 0, outputs are forced: pc_reset = 1, pc_no_change = 11, all other outputs 0.
  - Reset mid-drain or mid-vector aborts the interrupt with no ack.
- BOOT (one cycle): pc_reset = 1, flush = 1, pc_no_change = 11. Next state is RUN.
- RUN, evaluated in priority order:
  1. branch_taken: pc_wr_data = branch_target, pc_no_change = 00, flush = 1.
  2. ret_valid: pc_wr_data = ret_addr, pc_no_change = 00, flush = 1.
  3. int_req & int_armed: save_pc <= pc_cur; counter <= DRAIN_CYCLES-1; next state DRAIN. This cycle: pc_no_change = 01, pc_fetch_nop = 1.
  4. stall_req: pc_fetch_nop = 1, pc_wr_data = pc_cur, pc_no_change = 00.
  5. Otherwise: pc_wr_data = pc_cur + (instr_is_32 ? 2 : 1), pc_no_change = 00.
- Sequential PC arithmetic is modulo 2^PC_W: 32'hFFFFFFFF + 1 = 0, and 32'hFFFFFFFF + 2 = 1.
- A branch or return outranks the interrupt. A held int_req is taken on the next eligible RUN cycle.
- DRAIN:
  - pc_no_change = 01, pc_fetch_nop = 1, pc_wr_data = pc_cur.
  - Counter decrements each cycle; at 0, next state is VECTOR.
  - branch_taken in DRAIN: save_pc <= branch_target, flush = 1.
  - ret_valid in DRAIN: save_pc <= ret_addr.
  - If both are asserted, the branch wins.
  - stall_req is ignored in DRAIN.
- VECTOR (one cycle):
  - pc_load_vec = 1, int_ack = 1, int_save_valid = 1, int_save_pc = save_pc, flush = 1.
  - int_armed <= 0. Next state is RUN.
- int_armed returns to 1 on any cycle with int_req = 0. A level held across the ack never re-enters.
- int_save_pc always shows save_pc; int_save_valid qualifies it.
- pc_reset and pc_load_vec are never asserted together.
- pc_load_vec asserts only in VECTOR.

Optional Feature:
- Macro: PC_SEQ_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt, 16 bits: counts RUN cycles where rule 4 applied.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then release: expect pc_reset = 1 for the BOOT cycle. With pc_cur = 0 and instr_is_32 toggling 0,1,0, pc_wr_data sequence is 1, 2, 1 relative to each pc_cur.
- Wrap-around: pc_cur = 32'hFFFFFFFF, instr_is_32 = 1 -> pc_wr_data = 32'h1. With instr_is_32 = 0 -> 32'h0.
- Priority: branch_taken = 1 with target 32'h40, plus ret_valid and stall_req in the same cycle -> pc_wr_data = 32'h40, flush = 1, no fetch_nop. Next cycle, stall_req alone -> pc_fetch_nop = 1.
- Interrupt: int_req held at pc_cur = 32'h100, DRAIN_CYCLES = 3.
  - Entry cycle plus 3 DRAIN cycles with pc_no_change = 01.
  - Then VECTOR: pc_load_vec = 1, int_ack = 1, int_save_pc = 32'h100.
  - int_req still high afterwards -> no second ack until it drops and re-rises.
- Branch during drain: branch_taken with target 32'h200 in the 2nd DRAIN cycle -> int_save_pc = 32'h200 at VECTOR, flush pulses.
- Reset mid-drain: rst_n = 0 in DRAIN -> int_ack never asserts; BOOT follows release; int_save_pc = 0.

Source files
------------

// File: rtl/pc_seq_ctrl.sv
// Next-PC controller: boot, sequential, branch, return, hazard hold, interrupt entry.
// Optional stall_cnt output when PC_SEQ_STALL_CNT_EN is defined.
module pc_seq_ctrl #(
  parameter int PC_W = 32,
  parameter logic [PC_W-1:0] INT_VECTOR = 32'h20,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] pc_cur,
  input  logic            instr_is_32,
  input  logic            stall_req,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            ret_valid,
  input  logic [PC_W-1:0] ret_addr,
  input  logic            int_req,
  output logic [PC_W-1:0] pc_wr_data,
  output logic [1:0]      pc_no_change,
  output logic            pc_fetch_nop,
  output logic            pc_reset,
  output logic            pc_load_vec,
  output logic            flush,
  output logic            int_ack,
  output logic            int_save_valid,
  output logic [PC_W-1:0] int_save_pc
`ifdef PC_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_DRAIN,
    S_VECTOR
  } state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  state_t          state;
  logic [3:0]      cnt;
  logic [PC_W-1:0] save_pc;
  logic            armed;

  logic take_br;
  logic take_ret;
  logic take_int;
  logic take_stall;
  logic [PC_W-1:0] pc_step;

  // Mutually exclusive RUN rules, highest priority first.
  assign take_br    = branch_taken;
  assign take_ret   = !branch_taken && ret_valid;
  assign take_int   = !branch_taken && !ret_valid
                      && int_req && armed;
  assign take_stall = !branch_taken && !ret_valid
                      && !(int_req && armed) && stall_req;

  assign pc_step = pc_cur + (instr_is_32 ? PC_W'(2) : PC_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_BOOT;
      cnt     <= 4'd0;
      save_pc <= '0;
      armed   <= 1'b1;
    end else begin
      if (!int_req)
        armed <= 1'b1;
      else if (state == S_VECTOR)
        armed <= 1'b0;
      unique case (state)
        S_BOOT: state <= S_RUN;
        S_RUN: begin
          if (take_int) begin
            save_pc <= pc_cur;
            cnt     <= DRAIN_INIT;
            state   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (branch_taken)
            save_pc <= branch_target;
          else if (ret_valid)
            save_pc <= ret_addr;
          if (cnt == 4'd0)
            state <= S_VECTOR;
          else
            cnt <= cnt - 4'd1;
        end
        S_VECTOR: state <= S_RUN;
        default: state <= S_BOOT;
      endcase
    end
  end

  always_comb begin
    pc_wr_data     = '0;
    pc_no_change   = 2'b00;
    pc_fetch_nop   = 1'b0;
    pc_reset       = 1'b0;
    pc_load_vec    = 1'b0;
    flush          = 1'b0;
    int_ack        = 1'b0;
    int_save_valid = 1'b0;
    int_save_pc    = save_pc;
    if (!rst_n) begin
      pc_reset     = 1'b1;
      pc_no_change = 2'b11;
      int_save_pc  = '0;
    end else begin
      unique case (state)
        S_BOOT: begin
          pc_reset     = 1'b1;
          flush        = 1'b1;
          pc_no_change = 2'b11;
        end
        S_RUN: begin
          unique case (1'b1)
            take_br: begin
              pc_wr_data = branch_target;
              flush      = 1'b1;
            end
            take_ret: begin
              pc_wr_data = ret_addr;
              flush      = 1'b1;
            end
            take_int: begin
              pc_wr_data   = pc_cur;
              pc_no_change = 2'b01;
              pc_fetch_nop = 1'b1;
            end
            take_stall: begin
              pc_wr_data   = pc_cur;
              pc_fetch_nop = 1'b1;
            end
            default: pc_wr_data = pc_step;
          endcase
        end
        S_DRAIN: begin
          pc_wr_data   = pc_cur;
          pc_no_change = 2'b01;
          pc_fetch_nop = 1'b1;
          flush        = branch_taken;
        end
        S_VECTOR: begin
          pc_wr_data     = INT_VECTOR;
          pc_load_vec    = 1'b1;
          int_ack        = 1'b1;
          int_save_valid = 1'b1;
          flush          = 1'b1;
        end
        default: pc_no_change = 2'b11;
      endcase
    end
  end

`ifdef PC_SEQ_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt <= 16'd0;
    else if (state == S_RUN && take_stall
             && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: RUN vector table plus interrupt/reset sequences.
// Expected outputs are queued at drive time and checked mid-cycle.
module tb_pc_seq_ctrl;

  typedef struct packed {
    logic        rst_n;
    logic [31:0] pc;
    logic        i32;
    logic        stall;
    logic        bt;
    logic [31:0] tgt;
    logic        rv;
    logic [31:0] ra;
    logic        irq;
  } in_t;

  typedef struct packed {
    logic [31:0] wr;
    logic [1:0]  nc;
    logic        nop;
    logic        rst;
    logic        vec;
    logic        fl;
    logic        ack;
    logic        sv;
    logic [31:0] spc;
  } exp_t;

  typedef struct {
    string name;
    in_t   i;
    exp_t  e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_cur = '0;
  logic        instr_is_32 = 1'b0;
  logic        stall_req = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        ret_valid = 1'b0;
  logic [31:0] ret_addr = '0;
  logic        int_req = 1'b0;
  logic [31:0] pc_wr_data;
  logic [1:0]  pc_no_change;
  logic        pc_fetch_nop;
  logic        pc_reset;
  logic        pc_load_vec;
  logic        flush;
  logic        int_ack;
  logic        int_save_valid;
  logic [31:0] int_save_pc;
`ifdef PC_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_chk = 0;
  int n_pass = 0;
  exp_t  sb_q[$];
  string nm_q[$];
  vec_t  tbl[$];

  always #5 clk = ~clk;

  pc_seq_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_cur        (pc_cur),
    .instr_is_32   (instr_is_32),
    .stall_req     (stall_req),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .ret_valid     (ret_valid),
    .ret_addr      (ret_addr),
    .int_req       (int_req),
    .pc_wr_data    (pc_wr_data),
    .pc_no_change  (pc_no_change),
    .pc_fetch_nop  (pc_fetch_nop),
    .pc_reset      (pc_reset),
    .pc_load_vec   (pc_load_vec),
    .flush         (flush),
    .int_ack       (int_ack),
    .int_save_valid(int_save_valid),
    .int_save_pc   (int_save_pc)
`ifdef PC_SEQ_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  function automatic in_t mi(
    logic r, logic [31:0] pc, logic i32, logic st,
    logic bt, logic [31:0] tg, logic rv,
    logic [31:0] ra, logic irq);
    in_t v;
    v.rst_n = r;  v.pc = pc;  v.i32 = i32;
    v.stall = st; v.bt = bt;  v.tgt = tg;
    v.rv = rv;    v.ra = ra;  v.irq = irq;
    return v;
  endfunction

  function automatic exp_t me(
    logic [31:0] wr, logic [1:0] nc, logic nop,
    logic rs, logic vec, logic fl, logic ack,
    logic sv, logic [31:0] spc);
    exp_t v;
    v.wr = wr;   v.nc = nc;   v.nop = nop;
    v.rst = rs;  v.vec = vec; v.fl = fl;
    v.ack = ack; v.sv = sv;   v.spc = spc;
    return v;
  endfunction

  function automatic exp_t seq(logic [31:0] wr, logic [31:0] spc);
    return me(wr, 2'b00, 0, 0, 0, 0, 0, 0, spc);
  endfunction

  function automatic exp_t drn(logic [31:0] pc, logic fl,
                               logic [31:0] spc);
    return me(pc, 2'b01, 1, 0, 0, fl, 0, 0, spc);
  endfunction

  task automatic apply(input string nm, input in_t i, input exp_t e);
    exp_t got;
    exp_t want;
    string wn;
    @(posedge clk);
    #1;
    rst_n         = i.rst_n;
    pc_cur        = i.pc;
    instr_is_32   = i.i32;
    stall_req     = i.stall;
    branch_taken  = i.bt;
    branch_target = i.tgt;
    ret_valid     = i.rv;
    ret_addr      = i.ra;
    int_req       = i.irq;
    sb_q.push_back(e);
    nm_q.push_back(nm);
    #3;
    want = sb_q.pop_front();
    wn   = nm_q.pop_front();
    got = me(pc_wr_data, pc_no_change, pc_fetch_nop, pc_reset,
             pc_load_vec, flush, int_ack, int_save_valid,
             int_save_pc);
    n_chk++;
    if (got === want)
      n_pass++;
    else
      $display("FAIL %s: got wr=%h nc=%b nop=%b rst=%b vec=%b fl=%b ack=%b sv=%b spc=%h, exp wr=%h nc=%b nop=%b rst=%b vec=%b fl=%b ack=%b sv=%b spc=%h",
               wn, got.wr, got.nc, got.nop, got.rst, got.vec,
               got.fl, got.ack, got.sv, got.spc,
               want.wr, want.nc, want.nop, want.rst, want.vec,
               want.fl, want.ack, want.sv, want.spc);
  endtask

  initial begin
    exp_t rst_e;
    exp_t boot_e;
    exp_t vec_e;
    rst_e  = me(0, 2'b11, 0, 1, 0, 0, 0, 0, 0);
    boot_e = me(0, 2'b11, 0, 1, 0, 1, 0, 0, 0);

    tbl.push_back('{"seq0",  mi(1, 0, 0, 0, 0, 0, 0, 0, 0), seq(1, 0)});
    tbl.push_back('{"seq1",  mi(1, 0, 1, 0, 0, 0, 0, 0, 0), seq(2, 0)});
    tbl.push_back('{"seq2",  mi(1, 0, 0, 0, 0, 0, 0, 0, 0), seq(1, 0)});
    tbl.push_back('{"wrap2", mi(1, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0),
                    seq(32'h1, 0)});
    tbl.push_back('{"wrap1", mi(1, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0),
                    seq(32'h0, 0)});
    tbl.push_back('{"seq32", mi(1, 32'h1234, 1, 0, 0, 0, 0, 0, 0),
                    seq(32'h1236, 0)});
    tbl.push_back('{"br_pri", mi(1, 32'h10, 0, 1, 1, 32'h40, 1, 32'h80, 0),
                    me(32'h40, 0, 0, 0, 0, 1, 0, 0, 0)});
    tbl.push_back('{"stall", mi(1, 32'h40, 0, 1, 0, 0, 0, 0, 0),
                    me(32'h40, 0, 1, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{"ret_pri", mi(1, 32'h41, 0, 1, 0, 0, 1, 32'h80, 0),
                    me(32'h80, 0, 0, 0, 0, 1, 0, 0, 0)});
    tbl.push_back('{"stall32", mi(1, 32'h50, 1, 1, 0, 0, 0, 0, 0),
                    me(32'h50, 0, 1, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{"br_irq", mi(1, 32'h58, 0, 0, 1, 32'h60, 0, 0, 1),
                    me(32'h60, 0, 0, 0, 0, 1, 0, 0, 0)});

    apply("reset0", mi(0, 0, 0, 0, 0, 0, 0, 0, 0), rst_e);
    apply("reset1", mi(0, 0, 0, 0, 0, 0, 0, 0, 0), rst_e);
    apply("boot",   mi(1, 0, 0, 0, 0, 0, 0, 0, 0), boot_e);

    foreach (tbl[k])
      apply(tbl[k].name, tbl[k].i, tbl[k].e);

    // held request taken after the branch cycle, saved PC 0x100
    apply("int_entry", mi(1, 32'h100, 0, 0, 0, 0, 0, 0, 1),
          drn(32'h100, 0, 0));
    apply("drain1", mi(1, 32'h100, 0, 0, 0, 0, 0, 0, 1),
          drn(32'h100, 0, 32'h100));
    apply("drain2", mi(1, 32'h100, 0, 0, 0, 0, 0, 0, 1),
          drn(32'h100, 0, 32'h100));
    apply("drain3", mi(1, 32'h100, 0, 0, 0, 0, 0, 0, 1),
          drn(32'h100, 0, 32'h100));
    vec_e = me(32'h20, 0, 0, 0, 1, 1, 1, 1, 32'h100);
    apply("vector", mi(1, 32'h100, 0, 0, 0, 0, 0, 0, 1), vec_e);
    apply("held_noreent0", mi(1, 32'h20, 0, 0, 0, 0, 0, 0, 1),
          seq(32'h21, 32'h100));
    apply("held_noreent1", mi(1, 32'h21, 0, 0, 0, 0, 0, 0, 1),
          seq(32'h22, 32'h100));
    apply("irq_drop", mi(1, 32'h22, 0, 0, 0, 0, 0, 0, 0),
          seq(32'h23, 32'h100));

    // re-entry, branch to 0x200 during the second drain cycle
    apply("int_entry2", mi(1, 32'h23, 0, 0, 0, 0, 0, 0, 1),
          drn(32'h23, 0, 32'h100));
    apply("d2_drain1", mi(1, 32'h23, 0, 0, 0, 0, 0, 0, 0),
          drn(32'h23, 0, 32'h23));
    apply("d2_drain2_br", mi(1, 32'h23, 0, 1, 1, 32'h200, 0, 0, 0),
          drn(32'h23, 1, 32'h23));
    apply("d2_drain3", mi(1, 32'h23, 0, 0, 0, 0, 0, 0, 0),
          drn(32'h23, 0, 32'h200));
    vec_e = me(32'h20, 0, 0, 0, 1, 1, 1, 1, 32'h200);
    apply("vector2", mi(1, 32'h23, 0, 0, 0, 0, 0, 0, 0), vec_e);
    apply("post_vec2", mi(1, 32'h20, 0, 0, 0, 0, 0, 0, 0),
          seq(32'h21, 32'h200));

    // reset while draining aborts the entry
    apply("int_entry3", mi(1, 32'h300, 0, 0, 0, 0, 0, 0, 1),
          drn(32'h300, 0, 32'h200));
    apply("d3_drain1", mi(1, 32'h300, 0, 0, 0, 0, 0, 0, 1),
          drn(32'h300, 0, 32'h300));
    apply("mid_reset", mi(0, 32'h300, 0, 0, 0, 0, 0, 0, 1), rst_e);
    apply("boot2", mi(1, 32'h300, 0, 0, 0, 0, 0, 0, 0), boot_e);
    apply("after_boot0", mi(1, 32'h0, 0, 0, 0, 0, 0, 0, 0),
          seq(32'h1, 0));
    apply("after_boot1", mi(1, 32'h1, 1, 0, 0, 0, 0, 0, 0),
          seq(32'h3, 0));
    apply("after_boot2", mi(1, 32'h3, 0, 0, 0, 0, 0, 0, 0),
          seq(32'h4, 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
